uart: RTL and testbench

//  8N1 UART for the Tang Nano 9K board top: receiver drives the six on-board LEDs,

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_engine.sv | 110 +++++++++++
 rtl/uart.sv | 120 ++++++++++++
 tb/tb_uart.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encoding and frame geometry.
// Both the RX FSM in the top and the TX engine use the same state names.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int         DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_engine.sv
// 8N1 transmitter: accepts one byte while idle and shifts it out LSB first,
// holding every bit for BAUD_DIV clocks; tx_done marks the last stop-bit clock.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_tx,
    input  logic [7:0] tx_data,
    output logic       uart_tx,
    output logic       tx_done
);

    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(BAUD_DIV - 2);

    uart_state_e   state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic          tx_r, tx_s;
    logic          done_r, done_s;

    // Next-state logic; the line level is computed for the state being entered.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s     = {CW{1'b0}};
                bit_idx_s = 3'd0;
                if (enable_tx) begin
                    shift_s = tx_data;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (bit_idx_r == LAST_BIT) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    done_s  = (cnt_r == CNT_DONE);
                end
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
            done_r    <= done_s;
        end
    end

    assign uart_tx = tx_r;
    assign tx_done = done_r;

endmodule

// File: rtl/uart.sv
// Board-level 8N1 UART: receiver with 2-FF synchronizer driving active-low LEDs
// from the last good byte, plus the TX engine for user-supplied bytes.
module uart
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [5:0] led,
    input  logic       enable_tx,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic          rx_meta_r, rx_sync_r;
    uart_state_e   rx_state_r, rx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]    rx_bit_r, rx_bit_s;
    logic [7:0]    rx_shift_r, rx_shift_s;
    logic [5:0]    led_r, led_s;

    // RX next-state logic; every sample is taken at the middle of its bit.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        led_s      = led_r;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = {CW{1'b0}};
                rx_bit_s = 3'd0;
                if (!rx_sync_r) begin
                    rx_state_s = ST_START;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s   = {CW{1'b0}};
                    rx_state_s = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_s   = rx_cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = {CW{1'b0}};
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == LAST_BIT) begin
                        rx_state_s = ST_STOP;
                    end else begin
                        rx_bit_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = {CW{1'b0}};
                    rx_state_s = ST_IDLE;
                    if (rx_sync_r) begin
                        led_s = ~rx_shift_r[5:0];
                    end else begin
                        led_s = led_r;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
            end
        endcase
    end

    // Synchronizer, RX state and LED registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= {CW{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            led_r      <= 6'b111111;
        end else begin
            rx_meta_r  <= uart_rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            led_r      <= led_s;
        end
    end

    assign led = led_r;

    uart_tx_engine #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .enable_tx (enable_tx),
        .tx_data   (tx_data),
        .uart_tx   (uart_tx),
        .tx_done   (tx_done)
    );

endmodule

// File: tb/tb_uart.sv
// Bench for uart at BAUD_DIV=8: directed and random RX/TX frames checked against
// a frame-level model (expected LED value, expected line level per clock).
module tb_uart;

    localparam int BAUD_DIV = 8;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_drv;
    logic       loop_en;
    logic       uart_rx_s;
    logic       uart_tx;
    logic [5:0] led;
    logic       enable_tx;
    logic [7:0] tx_data;
    logic       tx_done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] exp_led;

    assign uart_rx_s = loop_en ? uart_tx : rx_drv;

    uart #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx_s),
        .uart_tx   (uart_tx),
        .led       (led),
        .enable_tx (enable_tx),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one serial frame on uart_rx, then idle; the model updates the LED on a good stop bit.
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok, input int idle_after);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BAUD_DIV; c++) begin
                @(negedge clk);
                rx_drv = bits[i];
            end
        end
        for (int c = 0; c < idle_after; c++) begin
            @(negedge clk);
            rx_drv = 1'b1;
        end
        if (stop_ok) exp_led = ~b[5:0];
    endtask

    // Check one transmitted frame clock by clock; caller has already presented the request.
    task automatic tx_frame(input logic [7:0] b, input logic keep);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (!keep) enable_tx = 1'b0;
            tx_data = 8'($urandom);
            check("tx_line", uart_tx, bits[(k - 1) / BAUD_DIV]);
            check("tx_done", tx_done, (k == FRAME));
        end
    endtask

    task automatic tx_pulse(input logic [7:0] b);
        @(negedge clk);
        check("tx_idle_before", uart_tx, 1'b1);
        enable_tx = 1'b1;
        tx_data   = b;
        tx_frame(b, 1'b0);
        @(negedge clk);
        check("tx_idle_after", uart_tx, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;

        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; enable_tx = 1'b0; tx_data = 8'h00;
        exp_led = 6'b111111;
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_led", led, 6'b111111);
        check("rst_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        rx_frame(8'h61, 1'b1, 16);
        check("rx_61", led, 6'b011110);
        check("rx_61_model", led, exp_led);

        rx_frame(8'hFF, 1'b0, 24);
        check("rx_frame_err", led, 6'b011110);

        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("rx_glitch", led, 6'b011110);

        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(3) != 0);
            rx_frame(b, ok, 24);
            check("rx_rand", led, exp_led);
        end

        tx_pulse(8'hA5);

        @(negedge clk);
        enable_tx = 1'b1;
        tx_data   = 8'h00;
        tx_frame(8'h00, 1'b1);
        tx_data = 8'hFF;
        @(negedge clk);
        check("b2b_gap_line", uart_tx, 1'b1);
        check("b2b_gap_done", tx_done, 1'b0);
        tx_frame(8'hFF, 1'b0);
        @(negedge clk);
        check("b2b_end_line", uart_tx, 1'b1);

        for (int n = 0; n < 3; n++) begin
            tx_pulse(8'($urandom));
        end

        loop_en = 1'b1;
        tx_pulse(8'h3C);
        exp_led = ~6'h3C;
        repeat (20) @(negedge clk);
        check("loop_3c", led, 6'b000011);
        b = 8'($urandom);
        tx_pulse(b);
        exp_led = ~b[5:0];
        repeat (20) @(negedge clk);
        check("loop_rand", led, exp_led);
        loop_en = 1'b0;

        // Reset in the middle of simultaneous RX and TX frames.
        @(negedge clk);
        enable_tx = 1'b1;
        tx_data   = 8'h00;
        rx_drv    = 1'b0;
        @(negedge clk);
        enable_tx = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_led = 6'b111111;
        check("mid_rst_led", led, 6'b111111);
        check("mid_rst_tx", uart_tx, 1'b1);
        repeat (100) @(negedge clk);
        check("post_rst_tx", uart_tx, 1'b1);
        check("post_rst_led", led, exp_led);

        b = 8'($urandom);
        rx_frame(b, 1'b1, 16);
        check("rx_after_rst", led, exp_led);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
